// File: rtl/pig_tracker_multi.sv
// Player-position tracker with NUM_ITEMS grow/shrink collectibles, field clamping,
// size growth, saturating score and an IDLE/RUN/OVER game state machine.
module pig_tracker_multi #(
  parameter int COORD_W    = 11,
  parameter int NUM_ITEMS  = 4,
  parameter int SCORE_W    = 8,
  parameter int STEP       = 4,
  parameter int BASE_SIZE  = 16,
  parameter int GROWTH     = 8,
  parameter int SHRINK     = 8,
  parameter int MAX_GROWTH = 64,
  parameter int MIN_X      = 0,
  parameter int MAX_X      = 639,
  parameter int MIN_Y      = 0,
  parameter int MAX_Y      = 479,
  parameter int START_X    = 312,
  parameter int START_Y    = 232
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic                                                game_over,
  input  logic                                                move_tick,
  input  logic                                                up,
  input  logic                                                down,
  input  logic                                                left,
  input  logic                                                right,
  input  logic [NUM_ITEMS-1:0]                                item_valid,
  input  logic [NUM_ITEMS-1:0]                                item_shrink,
  input  logic [NUM_ITEMS*COORD_W-1:0]                        item_x,
  input  logic [NUM_ITEMS*COORD_W-1:0]                        item_y,
  input  logic [COORD_W-1:0]                                  item_size,
  output logic [COORD_W-1:0]                                  pos_x,
  output logic [COORD_W-1:0]                                  pos_y,
  output logic [COORD_W-1:0]                                  pos_x_end,
  output logic [COORD_W-1:0]                                  pos_y_end,
  output logic [COORD_W-1:0]                                  growth,
  output logic [SCORE_W-1:0]                                  score,
  output logic                                                hit,
  output logic [((NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1)-1:0] hit_idx,
  output logic [1:0]                                          state
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;

  localparam coord_t STEP_C   = coord_t'(STEP);
  localparam coord_t BASE_C   = coord_t'(BASE_SIZE);
  localparam coord_t GROWTH_C = coord_t'(GROWTH);
  localparam coord_t SHRINK_C = coord_t'(SHRINK);
  localparam coord_t MAXG_C   = coord_t'(MAX_GROWTH);
  localparam coord_t MIN_XC   = coord_t'(MIN_X);
  localparam coord_t MAX_XC   = coord_t'(MAX_X);
  localparam coord_t MIN_YC   = coord_t'(MIN_Y);
  localparam coord_t MAX_YC   = coord_t'(MAX_Y);
  localparam coord_t START_XC = coord_t'(START_X);
  localparam coord_t START_YC = coord_t'(START_Y);

  state_t             st;
  coord_t             px, py, gr;
  logic [SCORE_W-1:0] sc;
  logic               d_up, d_dn, d_lf, d_rt;

  logic               mv_any, mv_vert, mv_back;
  coord_t             cx, cy, size, isz;
  logic               in_field, found, shrink;
  logic [IDX_W-1:0]   fidx;
  coord_t             ng, delta, hx, hy, lim_x, lim_y;

  // Candidate step, field check and lowest-index overlap search
  always_comb begin
    coord_t ix, iy;
    mv_any  = d_up | d_dn | d_lf | d_rt;
    mv_vert = d_up | d_dn;
    mv_back = d_up | (d_lf & ~d_dn & ~d_rt);
    cx      = px;
    cy      = py;
    if (d_up)      cy = py - STEP_C;
    else if (d_dn) cy = py + STEP_C;
    else if (d_rt) cx = px + STEP_C;
    else if (d_lf) cx = px - STEP_C;
    size     = BASE_C + gr;
    isz      = $signed(item_size);
    in_field = (cx >= MIN_XC) && (cy >= MIN_YC) &&
               (cx + size <= MAX_XC) && (cy + size <= MAX_YC);
    found = 1'b0;
    fidx  = '0;
    ix    = '0;
    iy    = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      ix = $signed(item_x[i*COORD_W +: COORD_W]);
      iy = $signed(item_y[i*COORD_W +: COORD_W]);
      if (!found && item_valid[i] &&
          (cx > ix - size) && (cx < ix + isz) &&
          (cy > iy - size) && (cy < iy + isz)) begin
        found = 1'b1;
        fidx  = IDX_W'(i);
      end
    end
  end

  // Hit outcome: recentre by half the real growth delta, then clamp into the field
  always_comb begin
    shrink = item_shrink[fidx];
    hx     = cx;
    hy     = cy;
    if (shrink) begin
      ng    = (gr >= SHRINK_C) ? gr - SHRINK_C : '0;
      delta = gr - ng;
      if (mv_vert) hx = cx + (delta >>> 1);
      else         hy = cy + (delta >>> 1);
    end else begin
      ng    = (gr + GROWTH_C > MAXG_C) ? MAXG_C : gr + GROWTH_C;
      delta = ng - gr;
      if (mv_vert) hx = cx - (delta >>> 1);
      else         hy = cy - (delta >>> 1);
      if (mv_back) begin
        if (mv_vert) hy = hy - delta;
        else         hx = hx - delta;
      end
    end
    lim_x = MAX_XC - BASE_C - ng;
    lim_y = MAX_YC - BASE_C - ng;
    if (hx < MIN_XC)     hx = MIN_XC;
    else if (hx > lim_x) hx = lim_x;
    if (hy < MIN_YC)     hy = MIN_YC;
    else if (hy > lim_y) hy = lim_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      px      <= START_XC;
      py      <= START_YC;
      gr      <= '0;
      sc      <= '0;
      hit     <= 1'b0;
      hit_idx <= '0;
      d_up    <= 1'b0;
      d_dn    <= 1'b0;
      d_lf    <= 1'b0;
      d_rt    <= 1'b0;
    end else begin
      d_up <= up;
      d_dn <= down;
      d_lf <= left;
      d_rt <= right;
      hit  <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (start) begin
            st <= RUN;
            px <= START_XC;
            py <= START_YC;
            gr <= '0;
            sc <= '0;
          end
        end
        RUN: begin
          if (game_over) begin
            st <= OVER;
          end else if (move_tick && mv_any && in_field) begin
            if (found) begin
              px      <= hx;
              py      <= hy;
              gr      <= ng;
              hit     <= 1'b1;
              hit_idx <= fidx;
              if (!shrink && sc != '1) sc <= sc + 1'b1;
            end else begin
              px <= cx;
              py <= cy;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign pos_x     = px;
  assign pos_y     = py;
  assign pos_x_end = px + BASE_C + gr;
  assign pos_y_end = py + BASE_C + gr;
  assign growth    = gr;
  assign score     = sc;
  assign state     = st;

endmodule
